// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer and its cursor.
package console_pkg;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;
  localparam int ADDR_W   = 12;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 5;

  typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_e;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_s;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction
endpackage

// File: rtl/console_cursor.sv
// Cursor position register with column/row wrap. row_wrap flags that the
// requested step takes the row from ROWS-1 back to 0 this cycle.
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_col,
  input  logic             inc_row,
  input  logic             dec_col,
  input  logic             col_zero,
  input  logic             home,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             row_wrap
);
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic last_col, last_row, row_step;

  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign row_step = inc_row | (inc_col & last_col);
  assign row_wrap = row_step & last_row & ~home;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home) begin
      col_d = '0;
      row_d = '0;
    end else begin
      if (inc_col)       col_d = last_col ? '0 : col_q + 1'b1;
      else if (dec_col)  col_d = (col_q == '0) ? '0 : col_q - 1'b1;
      else if (col_zero) col_d = '0;
      if (row_step)      row_d = last_row ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;
endmodule

// File: rtl/text_console_writer.sv
// ASCII byte stream to character-RAM writer with line/screen clear.
// Define CONSOLE_CLEAR_ON_RESET_EN to clear the whole screen after reset release.
module text_console_writer
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row
);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam logic INIT_CLR = 1'b1;
`else
  localparam logic INIT_CLR = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LINE_N   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCREEN_N = ADDR_W'(COLS * ROWS);

  state_e            state_q, state_d;
  wr_s               wr_q, wr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              inc_col, inc_row, dec_col, col_zero, home, row_wrap;
  logic              take;
  logic [ADDR_W-1:0] cur_addr;

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_col  (inc_col),
    .inc_row  (inc_row),
    .dec_col  (dec_col),
    .col_zero (col_zero),
    .home     (home),
    .col      (cursor_col),
    .row      (cursor_row),
    .row_wrap (row_wrap)
  );

  assign in_ready = rst_n && (state_q == IDLE) && !init_q;
  assign take     = in_valid && in_ready;
  assign cur_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

  // Both clears start at address 0: a line clear only follows a wrap to row 0.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    wr_d.en  = 1'b0;
    cnt_d    = cnt_q;
    init_d   = init_q;
    inc_col  = 1'b0;
    inc_row  = 1'b0;
    dec_col  = 1'b0;
    col_zero = 1'b0;
    home     = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_q) begin
          init_d  = 1'b0;
          state_d = CLR_SCREEN;
          wr_d    = '{1'b1, '0, SPACE};
          cnt_d   = ADDR_W'(1);
        end else if (take) begin
          if (is_printable(in_data)) begin
            state_d = WRITE;
            wr_d    = '{1'b1, cur_addr, in_data};
          end else begin
            case (in_data)
              CR: col_zero = 1'b1;
              LF: begin
                inc_row = 1'b1;
                if (row_wrap) begin
                  state_d = CLR_LINE;
                  wr_d    = '{1'b1, '0, SPACE};
                  cnt_d   = ADDR_W'(1);
                end
              end
              BS: dec_col = 1'b1;
              FF: begin
                state_d = CLR_SCREEN;
                wr_d    = '{1'b1, '0, SPACE};
                cnt_d   = ADDR_W'(1);
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        inc_col = 1'b1;
        if (row_wrap) begin
          state_d = CLR_LINE;
          wr_d    = '{1'b1, '0, SPACE};
          cnt_d   = ADDR_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CLR_LINE, CLR_SCREEN: begin
        if (cnt_q == ((state_q == CLR_LINE) ? LINE_N : SCREEN_N)) begin
          home    = 1'b1;
          state_d = IDLE;
        end else begin
          wr_d  = '{1'b1, cnt_q, SPACE};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cnt_q   <= '0;
      init_q  <= INIT_CLR;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

  assign wr_en   = wr_q.en;
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;
endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 The module SHALL have parameter COLS, default 80, meaning characters per row of the text buffer.
REQ-002 The module SHALL have parameter ROWS, default 30, meaning text rows in the buffer.
REQ-003 The module SHALL have port clk  input  1  the single system clock; all logic samples on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  an ASCII byte is offered.
REQ-006 The module SHALL have port in_data  input  8  the offered ASCII byte.
REQ-007 The module SHALL have port in_ready  output  1  the writer accepts a byte this cycle.
REQ-008 The module SHALL have port wr_en  output  1  write strobe to the character RAM.
REQ-009 The module SHALL have port wr_addr  output  12  character RAM address, row*COLS+col.
REQ-010 The module SHALL have port wr_data  output  8  ASCII code written to the character RAM.
REQ-011 The module SHALL have port cursor_col  output  7  current cursor column.
REQ-012 The module SHALL have port cursor_row  output  5  current cursor row.

Function
REQ-013 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in state IDLE.
REQ-014 The FSM SHALL have states IDLE, WRITE, CLR_LINE and CLR_SCREEN.
REQ-015 A printable byte (0x20-0x7E) SHALL go IDLE->WRITE; in WRITE, wr_en=1, wr_addr=cursor address, wr_data=byte, for exactly one cycle; next cycle the cursor advances and the FSM returns to IDLE.
REQ-016 Advance: col+1; at col=COLS-1, col wraps to 0 and the row advances.
REQ-017 Row advance: row+1; at row=ROWS-1, row wraps to 0 and the FSM enters CLR_LINE instead of IDLE.
REQ-018 CLR_LINE SHALL write 0x20 to the COLS addresses of the new cursor row, one per cycle, col ascending, then go to IDLE with col=0.
REQ-019 0x0D (CR) SHALL set col=0; 0x0A (LF) SHALL perform a row advance without changing col; 0x08 (BS) SHALL decrement col, saturating at 0; none of these writes RAM.
REQ-020 0x0C (FF) SHALL enter CLR_SCREEN, write 0x20 to addresses 0..COLS*ROWS-1 ascending, one per cycle, then set the cursor to (0,0) and return to IDLE.
REQ-021 All other bytes SHALL be consumed with no write and no cursor change.
REQ-022 wr_en SHALL be 0 in IDLE; wr_addr and wr_data SHALL be registered outputs.
REQ-023 cursor_col and cursor_row SHALL be registered and change only on the cycle an FSM operation completes.

Reset
REQ-024 On rst_n=0, regardless of FSM state, including mid-clear: state=IDLE, cursor=(0,0), wr_en=0, wr_addr=0, wr_data=0, and in_ready=0 while rst_n is low.
REQ-025 The first cycle after rst_n deasserts SHALL follow REQ-030.

Configuration
REQ-026 The feature SHALL be controlled by macro CONSOLE_CLEAR_ON_RESET_EN.
REQ-027 When CONSOLE_CLEAR_ON_RESET_EN is defined, the first edge after reset release SHALL enter CLR_SCREEN, and in_ready SHALL stay 0 until the clear finishes.
REQ-028 When CONSOLE_CLEAR_ON_RESET_EN is undefined, the first edge after reset release SHALL find the FSM in IDLE with in_ready=1.

Structure
REQ-029 Package console_pkg SHALL hold COLS/ROWS defaults, ADDR_W=12, the state enum, and ASCII constants CR, LF, BS, FF and SPACE.
REQ-030 The post-reset state SHALL be CLR_SCREEN or IDLE, as selected by REQ-027/REQ-028.
REQ-031 Cursor counting and wrap logic SHALL be one sub-module, console_cursor, with inc_col, inc_row, dec_col and home inputs.

Verification
REQ-032 Reset, then send 'A' (0x41) at cursor (0,0) -> wr_en=1 for one cycle with wr_addr=0 and wr_data=0x41; cursor then reads (1,0).
REQ-033 Send 80 bytes 'x' from col 0, row 29 -> cursor wraps to (0,0); then 80 writes of 0x20 to addresses 0..79; in_ready is 0 throughout the clear.
REQ-034 From cursor (5,3), send CR then LF -> no wr_en; cursor reads (0,4).
REQ-035 From cursor (0,7), send BS -> cursor reads (0,7); send 0x7F -> byte is consumed with no write.
REQ-036 Send FF -> 2400 consecutive writes of 0x20, addresses 0..2399; cursor then reads (0,0); assert rst_n low mid-clear -> wr_en drops to 0 immediately.
REQ-037 Build with CONSOLE_CLEAR_ON_RESET_EN -> 2400 clear writes follow reset release before the first in_ready=1; build without it -> in_ready=1 on the first cycle after reset release.
